// File: rtl/pe_loop_sequencer_pkg.sv
// Shared definitions for the PE loop sequencer: FSM states, default loop
// limits and the address widths derived from them.
package PECtlCfg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int S_MAX_DEF = 4;
   localparam int C_MAX_DEF = 8;
   localparam int M_MAX_DEF = 8;
   localparam int W_MAX_DEF = 64;

   // Address width for a pad of the given depth; never narrower than one bit.
   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int IP_AW_DEF = addr_width(S_MAX_DEF * C_MAX_DEF);
   localparam int WP_AW_DEF = addr_width(S_MAX_DEF * C_MAX_DEF * M_MAX_DEF);
   localparam int PP_AW_DEF = addr_width(M_MAX_DEF);

endpackage

// File: rtl/pe_loop_sequencer_counter.sv
// Bounded up-counter: counts 0..bound-1 while enabled; wrap flags the last value.
module pe_loop_counter
   import PECtlCfg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] bound,
   output logic [WIDTH-1:0] count,
   output logic             wrap
);

   logic [WIDTH-1:0] count_reg;

   assign count = count_reg;
   assign wrap  = (count_reg == bound - WIDTH'(1));

   always_ff @(posedge clk) begin
      if (srst || clr) begin
         count_reg <= '0;
      end else if (en) begin
         count_reg <= wrap ? '0 : count_reg + WIDTH'(1);
      end
   end

endmodule

// File: rtl/pe_loop_sequencer.sv
// Loop-nest sequencer for a processing element: walks w/c/s/m, issues pad
// addresses and carries each token through a fetch -> mult -> sum pipeline.
module pe_loop_sequencer
   import PECtlCfg::*;
#(
   parameter int S_MAX = S_MAX_DEF,
   parameter int C_MAX = C_MAX_DEF,
   parameter int M_MAX = M_MAX_DEF,
   parameter int W_MAX = W_MAX_DEF,
   localparam int SW    = $clog2(S_MAX + 1),
   localparam int CW    = $clog2(C_MAX + 1),
   localparam int MW    = $clog2(M_MAX + 1),
   localparam int WW    = $clog2(W_MAX + 1),
   localparam int IP_AW = addr_width(S_MAX * C_MAX),
   localparam int WP_AW = addr_width(S_MAX * C_MAX * M_MAX),
   localparam int PP_AW = addr_width(M_MAX)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [SW-1:0]    i_cfg_s,
   input  logic [CW-1:0]    i_cfg_c,
   input  logic [MW-1:0]    i_cfg_m,
   input  logic [WW-1:0]    i_cfg_w,
   input  logic             i_stall,
   input  logic             i_win_valid,
   output logic             o_win_pop,
   output logic [IP_AW-1:0] o_ip_addr,
   output logic [WP_AW-1:0] o_wp_addr,
   output logic [PP_AW-1:0] o_pp_addr,
   output logic             o_fetch_valid,
   output logic             o_mult_valid,
   output logic             o_sum_valid,
   output logic             o_sum_fstpix,
   output logic             o_forward,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_cfg_err
);

   localparam int CNT_W = max_int(max_int(SW, CW), max_int(MW, WW));

   state_t state_reg, state_next;

   logic [SW-1:0] cfg_s_reg;
   logic [CW-1:0] cfg_c_reg;
   logic [MW-1:0] cfg_m_reg;
   logic [WW-1:0] cfg_w_reg;
   logic          drain_reg;
   logic          cfg_err_reg;

   logic cfg_ok, accept, fetch, pix_last, pass_last;

   // Counter chain index: 0=m (innermost), 1=s, 2=c, 3=w (outermost).
   logic [CNT_W-1:0] bound [4];
   logic [CNT_W-1:0] count [4];
   logic [3:0]       wrap;
   logic [4:0]       en_chain;

   logic [IP_AW-1:0] ip_next;
   logic [WP_AW-1:0] wp_next;

   logic             fetch_valid_reg, mult_valid_reg, sum_valid_reg;
   logic [IP_AW-1:0] ip_addr_reg;
   logic [WP_AW-1:0] wp_addr_reg;
   logic [PP_AW-1:0] pp_f_reg, pp_m_reg, pp_s_reg;
   logic             fst_f_reg, fst_m_reg, fst_s_reg;
   logic             fwd_f_reg, fwd_m_reg, fwd_s_reg;

   assign cfg_ok = (i_cfg_s != '0) && (i_cfg_s <= SW'(S_MAX)) &&
                   (i_cfg_c != '0) && (i_cfg_c <= CW'(C_MAX)) &&
                   (i_cfg_m != '0) && (i_cfg_m <= MW'(M_MAX)) &&
                   (i_cfg_w != '0) && (i_cfg_w <= WW'(W_MAX));

   assign accept = (state_reg == IDLE) && i_start && cfg_ok && !i_stall && !i_rst;
   assign fetch  = (state_reg == RUN) && i_win_valid && !i_stall && !i_rst;

   assign bound[0] = CNT_W'(cfg_m_reg);
   assign bound[1] = CNT_W'(cfg_s_reg);
   assign bound[2] = CNT_W'(cfg_c_reg);
   assign bound[3] = CNT_W'(cfg_w_reg);

   assign en_chain[0] = fetch;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_loop
         pe_loop_counter #(.WIDTH(CNT_W)) u_cnt (
            .clk   (i_clk),
            .srst  (i_rst),
            .en    (en_chain[gi]),
            .clr   (accept),
            .bound (bound[gi]),
            .count (count[gi]),
            .wrap  (wrap[gi])
         );
         assign en_chain[gi+1] = en_chain[gi] && wrap[gi];
      end
   endgenerate

   // A fetch that carries the m, s and c chains closes the current pixel.
   assign pix_last  = en_chain[3];
   assign pass_last = en_chain[4];
   assign o_win_pop = pix_last;

   assign ip_next = IP_AW'(int'(count[1]) * C_MAX + int'(count[2]));
   assign wp_next = WP_AW'((int'(count[1]) * C_MAX + int'(count[2])) * M_MAX + int'(count[0]));

   always_comb begin
      state_next = state_reg;
      o_busy     = 1'b0;
      o_done     = 1'b0;
      unique case (state_reg)
         IDLE:  if (i_start && cfg_ok) state_next = RUN;
         RUN: begin
            o_busy = 1'b1;
            if (pass_last) state_next = DRAIN;
         end
         DRAIN: begin
            o_busy = 1'b1;
            if (drain_reg) state_next = DONE;
         end
         DONE: begin
            o_done     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg       <= IDLE;
         cfg_s_reg       <= '0;
         cfg_c_reg       <= '0;
         cfg_m_reg       <= '0;
         cfg_w_reg       <= '0;
         drain_reg       <= 1'b0;
         cfg_err_reg     <= 1'b0;
         fetch_valid_reg <= 1'b0;
         mult_valid_reg  <= 1'b0;
         sum_valid_reg   <= 1'b0;
         ip_addr_reg     <= '0;
         wp_addr_reg     <= '0;
         pp_f_reg        <= '0;
         pp_m_reg        <= '0;
         pp_s_reg        <= '0;
         fst_f_reg       <= 1'b0;
         fst_m_reg       <= 1'b0;
         fst_s_reg       <= 1'b0;
         fwd_f_reg       <= 1'b0;
         fwd_m_reg       <= 1'b0;
         fwd_s_reg       <= 1'b0;
      end else if (!i_stall) begin
         state_reg   <= state_next;
         // DRAIN lasts exactly two cycles: enough for mult and sum to empty.
         drain_reg   <= (state_reg == DRAIN) && !drain_reg;
         cfg_err_reg <= (state_reg == IDLE) && i_start && !cfg_ok;
         if (accept) begin
            cfg_s_reg <= i_cfg_s;
            cfg_c_reg <= i_cfg_c;
            cfg_m_reg <= i_cfg_m;
            cfg_w_reg <= i_cfg_w;
         end

         fetch_valid_reg <= fetch;
         if (fetch) begin
            ip_addr_reg <= ip_next;
            wp_addr_reg <= wp_next;
            pp_f_reg    <= PP_AW'(count[0]);
            fst_f_reg   <= (count[1] == '0) && (count[2] == '0);
            fwd_f_reg   <= pix_last;
         end

         // Flags are qualified by valid so a bubble never carries stale markers.
         mult_valid_reg <= fetch_valid_reg;
         pp_m_reg       <= pp_f_reg;
         fst_m_reg      <= fetch_valid_reg && fst_f_reg;
         fwd_m_reg      <= fetch_valid_reg && fwd_f_reg;

         sum_valid_reg  <= mult_valid_reg;
         pp_s_reg       <= pp_m_reg;
         fst_s_reg      <= mult_valid_reg && fst_m_reg;
         fwd_s_reg      <= mult_valid_reg && fwd_m_reg;
      end
   end

   // The psum pad is touched by the sum stage, so its address leaves with that stage.
   assign o_ip_addr     = ip_addr_reg;
   assign o_wp_addr     = wp_addr_reg;
   assign o_pp_addr     = pp_s_reg;
   assign o_fetch_valid = fetch_valid_reg;
   assign o_mult_valid  = mult_valid_reg;
   assign o_sum_valid   = sum_valid_reg;
   assign o_sum_fstpix  = fst_s_reg;
   assign o_forward     = fwd_s_reg;
   assign o_cfg_err     = cfg_err_reg;

endmodule

// File: tb/tb_pe_loop_sequencer.sv
// Randomized bench for pe_loop_sequencer: expected token streams come from a
// plain loop-nest model and are matched in order against the pipeline outputs.
module tb_pe_loop_sequencer;

   localparam int S_MAX = 4;
   localparam int C_MAX = 8;
   localparam int M_MAX = 8;
   localparam int W_MAX = 64;
   localparam int SW    = $clog2(S_MAX + 1);
   localparam int CW    = $clog2(C_MAX + 1);
   localparam int MW    = $clog2(M_MAX + 1);
   localparam int WW    = $clog2(W_MAX + 1);
   localparam int IP_AW = PECtlCfg::addr_width(S_MAX * C_MAX);
   localparam int WP_AW = PECtlCfg::addr_width(S_MAX * C_MAX * M_MAX);
   localparam int PP_AW = PECtlCfg::addr_width(M_MAX);

   logic             clk = 1'b0;
   logic             i_rst, i_start, i_stall, i_win_valid;
   logic [SW-1:0]    i_cfg_s;
   logic [CW-1:0]    i_cfg_c;
   logic [MW-1:0]    i_cfg_m;
   logic [WW-1:0]    i_cfg_w;
   logic             o_win_pop, o_fetch_valid, o_mult_valid, o_sum_valid;
   logic             o_sum_fstpix, o_forward, o_busy, o_done, o_cfg_err;
   logic [IP_AW-1:0] o_ip_addr;
   logic [WP_AW-1:0] o_wp_addr;
   logic [PP_AW-1:0] o_pp_addr;

   pe_loop_sequencer dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .i_start       (i_start),
      .i_cfg_s       (i_cfg_s),
      .i_cfg_c       (i_cfg_c),
      .i_cfg_m       (i_cfg_m),
      .i_cfg_w       (i_cfg_w),
      .i_stall       (i_stall),
      .i_win_valid   (i_win_valid),
      .o_win_pop     (o_win_pop),
      .o_ip_addr     (o_ip_addr),
      .o_wp_addr     (o_wp_addr),
      .o_pp_addr     (o_pp_addr),
      .o_fetch_valid (o_fetch_valid),
      .o_mult_valid  (o_mult_valid),
      .o_sum_valid   (o_sum_valid),
      .o_sum_fstpix  (o_sum_fstpix),
      .o_forward     (o_forward),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_cfg_err     (o_cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct { int ip; int wp; } fetch_t;
   typedef struct { int pp; int fst; int fwd; } sum_t;

   fetch_t exp_f[$];
   sum_t   exp_s[$];

   int n_checks = 0;
   int n_bad    = 0;

   int pass_id = 0, seen_pass = 0, cyc = 0;
   int f_idx, s_idx, n_fetch, n_fst, n_fwd, n_pop, n_done, last_fv_cyc, done_cyc;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int out_vec();
      return int'({o_win_pop, o_fetch_valid, o_mult_valid, o_sum_valid, o_sum_fstpix,
                   o_forward, o_busy, o_done, o_cfg_err, o_ip_addr, o_wp_addr, o_pp_addr});
   endfunction

   // Reference: the loop nest written out directly, outer w to inner m.
   task automatic build_model(input int s, input int c, input int m, input int w);
      exp_f.delete();
      exp_s.delete();
      for (int wi = 0; wi < w; wi++)
         for (int ci = 0; ci < c; ci++)
            for (int si = 0; si < s; si++)
               for (int mi = 0; mi < m; mi++) begin
                  fetch_t f;
                  sum_t   t;
                  f.ip  = si * C_MAX + ci;
                  f.wp  = (si * C_MAX + ci) * M_MAX + mi;
                  t.pp  = mi;
                  t.fst = (ci == 0 && si == 0) ? 1 : 0;
                  t.fwd = (ci == c-1 && si == s-1 && mi == m-1) ? 1 : 0;
                  exp_f.push_back(f);
                  exp_s.push_back(t);
               end
   endtask

   task automatic monitor();
      bit stall_e, rst_e;
      int p_fv = 0, p_mv = 0, p_sv = 0, p_ip = 0, p_wp = 0, p_pp = 0;
      forever begin
         @(posedge clk);
         stall_e = i_stall;
         rst_e   = i_rst;
         cyc++;
         @(negedge clk);
         if (pass_id != seen_pass) begin
            seen_pass = pass_id;
            f_idx = 0; s_idx = 0; n_fetch = 0; n_fst = 0; n_fwd = 0;
            n_pop = 0; n_done = 0; last_fv_cyc = 0; done_cyc = 0;
         end
         if (o_win_pop) n_pop++;
         if (!rst_e) begin
            if (stall_e) begin
               check_val("hold_fetch_valid", o_fetch_valid, p_fv);
               check_val("hold_mult_valid", o_mult_valid, p_mv);
               check_val("hold_sum_valid", o_sum_valid, p_sv);
               check_val("hold_ip", o_ip_addr, p_ip);
               check_val("hold_wp", o_wp_addr, p_wp);
               check_val("hold_pp", o_pp_addr, p_pp);
            end else begin
               check_val("mult_follows_fetch", o_mult_valid, p_fv);
               check_val("sum_follows_mult", o_sum_valid, p_mv);
               if (o_fetch_valid) begin
                  if (f_idx < exp_f.size()) begin
                     check_val("fetch_ip", o_ip_addr, exp_f[f_idx].ip);
                     check_val("fetch_wp", o_wp_addr, exp_f[f_idx].wp);
                  end else begin
                     check_val("fetch_overrun", f_idx + 1, exp_f.size());
                  end
                  f_idx++;
                  n_fetch++;
                  last_fv_cyc = cyc;
               end
               if (o_sum_valid) begin
                  if (s_idx < exp_s.size()) begin
                     check_val("sum_pp", o_pp_addr, exp_s[s_idx].pp);
                     check_val("sum_fstpix", o_sum_fstpix, exp_s[s_idx].fst);
                     check_val("sum_forward", o_forward, exp_s[s_idx].fwd);
                  end else begin
                     check_val("sum_overrun", s_idx + 1, exp_s.size());
                  end
                  s_idx++;
                  n_fst += int'(o_sum_fstpix);
                  n_fwd += int'(o_forward);
               end else begin
                  check_val("forward_without_sum", o_forward, 0);
               end
               if (o_done) begin
                  n_done++;
                  done_cyc = cyc;
               end
            end
         end
         p_fv = o_fetch_valid; p_mv = o_mult_valid; p_sv = o_sum_valid;
         p_ip = o_ip_addr;     p_wp = o_wp_addr;    p_pp = o_pp_addr;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cfg(input int s, input int c, input int m, input int w);
      i_cfg_s = SW'(s);
      i_cfg_c = CW'(c);
      i_cfg_m = MW'(m);
      i_cfg_w = WW'(w);
   endtask

   task automatic start_pass(input int s, input int c, input int m, input int w);
      build_model(s, c, m, w);
      pass_id++;
      drive_cfg(s, c, m, w);
      i_start = 1'b1;
      i_stall = 1'b0;
      tick();
      i_start = 1'b0;
   endtask

   // mode 0: random stall/valid plus ignored starts; 1: five-cycle stall burst;
   // 2: window gap of three cycles after the first pixel.
   task automatic run_pass(input int s, input int c, input int m, input int w,
                           input int stall_pct, input int wv_pct, input int mode, input bit lat);
      int k = 0, gap_left = 0;
      bit done_ok = 0, gap_used = 0;
      i_win_valid = 1'b1;
      start_pass(s, c, m, w);
      repeat (3000) begin
         if (o_done) begin
            done_ok = 1;
            break;
         end
         if (mode == 1) begin
            i_stall     = (k >= 4 && k < 9);
            i_win_valid = 1'b1;
         end else if (mode == 2) begin
            if (gap_left > 0) begin
               if (gap_left < 3) check_val("gap_no_fetch", o_fetch_valid, 0);
               i_win_valid = 1'b0;
               gap_left--;
            end else begin
               i_win_valid = 1'b1;
            end
         end else begin
            i_stall     = ($urandom_range(99) < stall_pct);
            i_win_valid = ($urandom_range(99) < wv_pct);
            i_start     = ($urandom_range(9) == 0);
            drive_cfg($urandom_range(7), $urandom_range(15), $urandom_range(15), $urandom_range(127));
         end
         #1;
         if (mode == 2 && !gap_used && o_win_pop) begin
            gap_used = 1;
            gap_left = 3;
         end
         k++;
         tick();
      end
      check_val("done_seen", done_ok, 1);
      i_start = 1'b0; i_stall = 1'b0; i_win_valid = 1'b0;
      tick();
      tick();
      check_val("fetch_count", n_fetch, s * c * m * w);
      check_val("sum_count", s_idx, s * c * m * w);
      check_val("fstpix_count", n_fst, w * m);
      check_val("forward_count", n_fwd, w);
      check_val("pop_count", n_pop, w);
      check_val("done_count", n_done, 1);
      check_val("idle_busy", o_busy, 0);
      // Done appears three cycles after the cycle that issued the last fetch.
      if (lat) check_val("done_latency", done_cyc - last_fv_cyc, 2);
      $display("pass s=%0d c=%0d m=%0d w=%0d mode=%0d fetches=%0d forwards=%0d", s, c, m, w, mode, n_fetch, n_fwd);
   endtask

   task automatic cfg_err_case(input int s, input int c, input int m, input int w);
      drive_cfg(s, c, m, w);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      check_val("cfg_err_pulse", o_cfg_err, 1);
      check_val("cfg_err_busy", o_busy, 0);
      tick();
      check_val("cfg_err_clear", o_cfg_err, 0);
      check_val("cfg_err_still_idle", o_busy, 0);
      $display("bad cfg s=%0d c=%0d m=%0d w=%0d rejected", s, c, m, w);
   endtask

   task automatic reset_in_drain();
      bit popped = 0;
      i_win_valid = 1'b1;
      start_pass(1, 1, 3, 1);
      for (int k = 0; k < 20; k++) begin
         if (o_win_pop) begin
            popped = 1;
            break;
         end
         tick();
      end
      check_val("drain_pop_seen", popped, 1);
      tick();
      tick();
      check_val("drain_busy", o_busy, 1);
      i_rst = 1'b1;
      tick();
      check_val("drain_rst_outputs", out_vec(), 0);
      i_rst = 1'b0;
      i_win_valid = 1'b0;
      tick();
      $display("reset during drain applied");
   endtask

   initial begin
      i_rst = 1'b1; i_start = 1'b0; i_stall = 1'b0; i_win_valid = 1'b0;
      drive_cfg(0, 0, 0, 0);
      fork
         monitor();
      join_none
      repeat (3) tick();
      check_val("rst_outputs", out_vec(), 0);
      i_rst = 1'b0;
      tick();

      cfg_err_case(2, 2, 0, 2);
      cfg_err_case(5, 1, 1, 1);
      cfg_err_case(1, 1, 1, 0);

      run_pass(3, 2, 2, 2, 0, 100, 0, 1);
      run_pass(1, 1, 1, 1, 0, 100, 0, 1);
      run_pass(4, 8, 8, 2, 0, 100, 0, 1);
      run_pass(2, 2, 2, 3, 0, 100, 1, 0);
      run_pass(2, 1, 2, 3, 0, 100, 2, 0);

      reset_in_drain();
      run_pass(1, 2, 2, 2, 0, 100, 0, 1);

      repeat (12) begin
         run_pass($urandom_range(1, S_MAX), $urandom_range(1, 3), $urandom_range(1, 3),
                  $urandom_range(1, 3), 20, 75, 0, 0);
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
